// File: rtl/fire_enc_lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fire_enc_lfsr_pkg
// Description : Shared constants for the Fire-code codec: code geometry,
//               generator polynomial g(x)=(x^15+1)(x^9+x^4+1) and the
//               encoder state encodings. Syndrome units reuse these too.
// Revision    : 1.0 - initial release
// ============================================================================
package fire_enc_lfsr_pkg;

    localparam int N     = 64;              // codeword length
    localparam int K     = 40;              // message length
    localparam int R     = N - K;           // parity length, degree of g(x)
    localparam int CNT_W = 6;               // width of the absorbed-bit counter

    // g(x) with the implicit x^24 term dropped: bits 19,15,9,4,0
    localparam logic [R-1:0] POLY = 24'h088211;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage : fire_enc_lfsr_pkg
`default_nettype wire

// File: rtl/fire_enc_lfsr_if.sv
`default_nettype none
// ============================================================================
// Module      : fire_enc_lfsr_if
// Description : Controller <-> encoder datapath bundle.
//   data_in   K  message, sampled on the start edge      (controller -> enc)
//   shift     1  absorb one message bit on this edge     (controller -> enc)
//   remainder R  running LFSR remainder, MSB = x^(R-1)   (enc -> controller)
//   count     6  message bits absorbed so far, 0..K      (enc -> controller)
//   busy      1  encoder is absorbing bits               (enc -> controller)
//   done      1  remainder is final                      (enc -> controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface fire_enc_lfsr_if;
    import fire_enc_lfsr_pkg::*;

    logic [K-1:0]     data_in;
    logic             shift;
    logic [R-1:0]     remainder;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output shift,
        input  remainder,
        input  count,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  shift,
        output remainder,
        output count,
        output busy,
        output done
    );

endinterface : fire_enc_lfsr_if
`default_nettype wire

// File: rtl/gf2_div_step.sv
`default_nettype none
// ============================================================================
// Module      : gf2_div_step
// Description : One step of serial polynomial division over GF(2) in Galois
//               form. Shifts the remainder up by one and folds in the next
//               dividend bit; when the coefficient leaving the top is set,
//               g(x) is subtracted (XOR with POLY).
//   i_rem      R  current remainder, MSB = x^(R-1) coefficient
//   i_bit      1  next dividend bit (MSB-first)
//   o_next_rem R  remainder after absorbing i_bit
// Revision    : 1.0 - initial release
// ============================================================================
module gf2_div_step #(
    parameter int           R    = 24,
    parameter logic [R-1:0] POLY = 24'h088211
) (
    input  wire logic [R-1:0] i_rem,
    input  wire logic         i_bit,
    output logic      [R-1:0] o_next_rem
);

    logic w_fb;

    assign w_fb       = i_bit ^ i_rem[R-1];
    assign o_next_rem = {i_rem[R-2:0], 1'b0} ^ (w_fb ? POLY : '0);

endmodule : gf2_div_step
`default_nettype wire

// File: rtl/fire_enc_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : fire_enc_lfsr
// Description : Serial Fire-code encoder datapath. On the start edge the
//               K-bit message is latched and its MSB absorbed; each further
//               shift edge absorbs the next bit into an R-bit Galois LFSR
//               dividing by g(x). After K bits the remainder equals
//               x^R*m(x) mod g(x) and done is raised.
//   clk   1  system clock, rising edge
//   rst   1  asynchronous, active-low reset
//   bus      fire_enc_lfsr_if.slave (data_in, shift, remainder, count,
//            busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
module fire_enc_lfsr
    import fire_enc_lfsr_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    fire_enc_lfsr_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(K);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_next;

    logic [K-1:0]     r_buf;
    logic [R-1:0]     r_rem;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_busy_d;
    logic             w_done_d;
    logic [R-1:0]     w_step_rem;
    logic             w_step_bit;
    logic [R-1:0]     w_next_rem;

    // ------------------------------------------------------------------
    // State register (busy/done are registered alongside the state so
    // every output comes straight from a flop)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // A one-bit message completes on its own start edge.
                if (bus.shift) begin
                    w_state_next = (c_cnt_one == c_cnt_full) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.shift && (r_count == c_cnt_last)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.shift) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_busy_d = 1'b0;
        w_done_d = 1'b0;
        if (r_state == ST_IDLE) begin
            w_load = bus.shift;
        end
        if (r_state == ST_RUN) begin
            w_step = bus.shift;
        end
        w_busy_d = (w_state_next == ST_RUN);
        w_done_d = (w_state_next == ST_DONE);
    end

    // A start restarts the division from zero using the incoming MSB,
    // so nothing from the previous job leaks into the new remainder.
    assign w_step_rem = w_load ? '0 : r_rem;
    assign w_step_bit = w_load ? bus.data_in[K-1] : r_buf[K-1];

    gf2_div_step #(
        .R    (R),
        .POLY (POLY)
    ) u_div_step (
        .i_rem      (w_step_rem),
        .i_bit      (w_step_bit),
        .o_next_rem (w_next_rem)
    );

    // ------------------------------------------------------------------
    // Datapath: message buffer, remainder, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf   <= '0;
            r_rem   <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_buf   <= bus.data_in << 1;
            r_rem   <= w_next_rem;
            r_count <= c_cnt_one;
        end else if (w_step) begin
            r_buf   <= r_buf << 1;
            r_rem   <= w_next_rem;
            r_count <= r_count + c_cnt_one;
        end
    end

    assign bus.remainder = r_rem;
    assign bus.count     = r_count;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule : fire_enc_lfsr
`default_nettype wire

// File: tb/tb_fire_enc_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tb_fire_enc_lfsr
// Description : Self-checking bench for fire_enc_lfsr. A reference model
//               computes the expected remainder by long division of
//               x^R * (message prefix) by g(x), and a compare process checks
//               every DUT output on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fire_enc_lfsr;

    localparam int K = fire_enc_lfsr_pkg::K;
    localparam int R = fire_enc_lfsr_pkg::R;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fire_enc_lfsr_if bus ();

    fire_enc_lfsr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // ------------------------------------------------------------------
    // Reference: remainder of x^R * (top j message bits) divided by
    // g(x) = (x^15+1)(x^9+x^4+1), by plain polynomial long division.
    // ------------------------------------------------------------------
    function automatic logic [R-1:0] fire_rem(input logic [K-1:0] m, input int j);
        logic [63:0] g;
        logic [63:0] v;
        g = (64'h211 << 15) ^ 64'h211;
        if (j == 0) return '0;
        v = 64'(m) >> (K - j);
        v = v << R;
        for (int i = K + R - 1; i >= R; i--) begin
            if (v[i]) v = v ^ (g << (i - R));
        end
        return v[R-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model of the job protocol
    // ------------------------------------------------------------------
    logic [K-1:0] m_msg  = '0;
    int           m_cnt  = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_msg  <= '0;
            m_cnt  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (m_done) begin
            if (!bus.shift) m_done <= 1'b0;
        end else if (m_busy) begin
            if (bus.shift) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == K) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (bus.shift) begin
            m_msg  <= bus.data_in;
            m_cnt  <= 1;
            m_busy <= (K != 1);
            m_done <= (K == 1);
        end
    end

    logic [R-1:0] exp_rem;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_rem = fire_rem(m_msg, m_cnt);
            n_vec++;
            if (bus.remainder !== exp_rem || bus.count !== 6'(m_cnt) ||
                bus.busy !== m_busy || bus.done !== m_done) begin
                n_err++;
                $display("FAIL per_cycle t=%0t got rem=%h cnt=%0d busy=%b done=%b, exp rem=%h cnt=%0d busy=%b done=%b",
                         $time, bus.remainder, bus.count, bus.busy, bus.done,
                         exp_rem, m_cnt, m_busy, m_done);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [K-1:0] rand_msg();
        return K'({$urandom, $urandom});
    endfunction

    // One encoder job as the controller runs it. Optionally pauses for 5
    // cycles at pause_at and holds shift for 'extra' edges in DONE.
    task automatic run_job(input logic [K-1:0] d, input int pause_at, input int extra,
                           output logic [R-1:0] res, output int lat);
        int cyc;
        bit paused;
        cyc    = 0;
        paused = 1'b0;
        lat    = -1;
        @(posedge clk); #1;
        bus.data_in = d;
        bus.shift   = 1'b1;
        while (cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            bus.data_in = rand_msg();   // must be ignored outside IDLE
            if (bus.done === 1'b1 && lat < 0) lat = cyc;
            if (bus.count == 6'(K)) break;
            if (!paused && pause_at >= 0 && bus.count == 6'(pause_at)) begin
                bus.shift = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                chk("pause_count_frozen", 64'(bus.count), 64'(pause_at));
                bus.shift = 1'b1;
                paused    = 1'b1;
            end
        end
        if (cyc >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL job_timeout: got count=%0d expected %0d", bus.count, K);
        end
        repeat (extra) begin @(posedge clk); #1; end
        res       = bus.remainder;
        bus.shift = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [K-1:0] a, b;
        logic [R-1:0] ra, rb, rab, r0, r1;
        logic [K-1:0] edge_msgs [3];
        int lat;
        int w;

        bus.data_in = '0;
        bus.shift   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_rem",   64'(bus.remainder), 64'd0);
        chk("reset_busy",  64'(bus.busy), 64'd0);
        chk("reset_done",  64'(bus.done), 64'd0);
        chk_en = 1'b1;
        rst    = 1'b1;

        // All-zero message
        run_job('0, -1, 0, r0, lat);
        chk("zero_rem", 64'(r0), 64'd0);
        chk("zero_count_retained", 64'(bus.count), 64'd40);
        chk("zero_done_dropped", 64'(bus.done), 64'd0);

        // m(x)=1 -> x^24 mod g = g - x^24
        run_job(K'(1), -1, 0, r0, lat);
        chk("one_rem", 64'(r0), 64'h088211);
        chk("one_latency", 64'(lat), 64'd40);

        // Boundary messages
        edge_msgs[0] = '1;
        edge_msgs[1] = K'(1) << (K - 1);
        edge_msgs[2] = K'(64'hA5A5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            run_job(edge_msgs[i], -1, 0, r0, lat);
            chk("edge_rem", 64'(r0), 64'(fire_rem(edge_msgs[i], K)));
        end

        // Pause at count 17 versus an uninterrupted run
        a = rand_msg();
        run_job(a, -1, 0, r0, lat);
        run_job(a, 17, 0, r1, lat);
        chk("pause_same_result", 64'(r1), 64'(r0));
        chk("pause_model", 64'(r1), 64'(fire_rem(a, K)));

        // Extra shift pulses while in DONE
        run_job(a, -1, 3, r1, lat);
        chk("done_ignores_shift", 64'(r1), 64'(r0));

        // Reset mid-job at count 20, then a fresh job
        @(posedge clk); #1;
        bus.data_in = rand_msg();
        bus.shift   = 1'b1;
        w = 0;
        while (bus.count != 6'd20 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL reset_wait: got count=%0d expected 20", bus.count);
        end
        rst = 1'b0;
        #1;
        chk("midrst_count", 64'(bus.count), 64'd0);
        chk("midrst_rem",   64'(bus.remainder), 64'd0);
        chk("midrst_busy",  64'(bus.busy), 64'd0);
        chk("midrst_done",  64'(bus.done), 64'd0);
        @(posedge clk); #1;
        bus.shift = 1'b0;
        rst       = 1'b1;
        b = rand_msg();
        run_job(b, -1, 0, r0, lat);
        chk("after_reset_job", 64'(r0), 64'(fire_rem(b, K)));

        // Linearity over random vectors
        for (int v = 0; v < 200; v++) begin
            a = rand_msg();
            b = rand_msg();
            run_job(a, -1, 0, ra, lat);
            run_job(b, -1, 0, rb, lat);
            run_job(a ^ b, -1, 0, rab, lat);
            chk("linearity", 64'(rab), 64'(ra ^ rb));
            chk("rand_model", 64'(ra), 64'(fire_rem(a, K)));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fire_enc_lfsr
`default_nettype wire
